// File: rtl/tq_pkg.sv
// Shared TQ-path definitions: TU size encodings, sequencer states, row-count helper.
package tq_pkg;

    // Transform-unit size encodings carried on tu_size
    localparam logic [1:0] TU4  = 2'd0;
    localparam logic [1:0] TU8  = 2'd1;
    localparam logic [1:0] TU16 = 2'd2;
    localparam logic [1:0] TU32 = 2'd3;

    // Transform sequencer states
    typedef enum logic [2:0] {
        IDLE,
        ROW_ISSUE,
        ROW_DRAIN,
        COL_ISSUE,
        COL_DRAIN,
        DONE
    } seq_state_e;

    // Number of rows (and columns) in a TU of the given size
    function automatic int unsigned tu_rows(input logic [1:0] sz);
        int unsigned n;
        case (sz)
            TU4:     n = 4;
            TU8:     n = 8;
            TU16:    n = 16;
            TU32:    n = 32;
            default: n = 4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tq_xfm_seq_if.sv
// Control/handshake bundle between the TQ controller, the transform sequencer,
// the transpose buffer and the shared 1-D transform datapath.
interface tq_xfm_seq_if #(
    parameter int unsigned ROW_W = 5
);
    logic             start;
    logic [1:0]       tu_size;
    logic             stall;
    logic             busy;
    logic             dp_en;
    logic             rd_en;
    logic [ROW_W-1:0] rd_idx;
    logic             pass;
    logic             wr_en;
    logic [ROW_W-1:0] wr_idx;
    logic             wr_pass;
    logic             done;

    // Controller / buffer side
    modport master (
        output start, tu_size, stall,
        input  busy, dp_en, rd_en, rd_idx, pass, wr_en, wr_idx, wr_pass, done
    );

    // Sequencer side
    modport slave (
        input  start, tu_size, stall,
        output busy, dp_en, rd_en, rd_idx, pass, wr_en, wr_idx, wr_pass, done
    );
endinterface

// File: rtl/tq_dly_line.sv
// Enable-gated fixed-depth shift register with asynchronous active-low clear.
// Used to align read-side tags with datapath results.
module tq_dly_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per enabled cycle; clear everything on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/tq_xfm_seq.sv
// Transform sequencer: drives one full row pass then one full column pass of the
// shared 1-D transform datapath over a TU, with write strobes aligned to the
// datapath latency and a one-cycle done pulse at the end.
module tq_xfm_seq
    import tq_pkg::*;
#(
    parameter int unsigned DP_LAT = 4,
    parameter int unsigned ROW_W  = 5
) (
    input  logic          clk,
    input  logic          rst,
    tq_xfm_seq_if.slave   bus
);

    seq_state_e       r_state;
    logic [1:0]       r_size;
    logic [ROW_W-1:0] r_idx;
    logic             r_pass;
    logic [3:0]       r_dcnt;

    logic [ROW_W-1:0] w_last;
    logic             w_issue;
    logic             w_run;
    logic [ROW_W+1:0] w_dly_d;
    logic [ROW_W+1:0] w_dly_q;

    assign w_last  = ROW_W'(tu_rows(r_size) - 1);
    assign w_issue = (r_state == ROW_ISSUE) || (r_state == COL_ISSUE);
    assign w_run   = ~bus.stall;

    // Sequencer FSM: everything holds while stalled, so done is deferred, not lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_size  <= TU4;
            r_idx   <= '0;
            r_pass  <= 1'b0;
            r_dcnt  <= '0;
        end else if (w_run) begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_size  <= bus.tu_size;
                        r_idx   <= '0;
                        r_pass  <= 1'b0;
                        r_state <= ROW_ISSUE;
                    end
                end
                ROW_ISSUE: begin
                    if (r_idx == w_last) begin
                        r_dcnt  <= '0;
                        r_state <= ROW_DRAIN;
                    end else begin
                        r_idx <= r_idx + ROW_W'(1);
                    end
                end
                ROW_DRAIN: begin
                    if (r_dcnt == 4'(DP_LAT - 1)) begin
                        r_idx   <= '0;
                        r_pass  <= 1'b1;
                        r_state <= COL_ISSUE;
                    end else begin
                        r_dcnt <= r_dcnt + 4'd1;
                    end
                end
                COL_ISSUE: begin
                    if (r_idx == w_last) begin
                        r_dcnt  <= '0;
                        r_state <= COL_DRAIN;
                    end else begin
                        r_idx <= r_idx + ROW_W'(1);
                    end
                end
                COL_DRAIN: begin
                    if (r_dcnt == 4'(DP_LAT - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_dcnt <= r_dcnt + 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read tag {valid, index, pass} travels with the data through the datapath
    assign w_dly_d = {w_issue, r_idx, r_pass};

    tq_dly_line #(
        .WIDTH (ROW_W + 2),
        .DEPTH (DP_LAT)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_run),
        .i_d  (w_dly_d),
        .o_q  (w_dly_q)
    );

    // Output decode: strobes are masked by stall, indices simply hold
    always_comb begin
        bus.busy    = (r_state != IDLE);
        bus.dp_en   = (r_state != IDLE) & w_run;
        bus.rd_en   = w_issue & w_run;
        bus.rd_idx  = r_idx;
        bus.pass    = r_pass;
        bus.wr_en   = w_dly_q[ROW_W+1] & w_run;
        bus.wr_idx  = w_dly_q[ROW_W:1];
        bus.wr_pass = w_dly_q[0];
        bus.done    = (r_state == DONE) & w_run;
    end

endmodule

// File: tb/tb_tq_xfm_seq.sv
// Bench for tq_xfm_seq: timeline model of one TU plus directed scenarios.
module tb_tq_xfm_seq;

    localparam int DP = 4;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tq_xfm_seq_if #(.ROW_W(RW)) bus ();

    tq_xfm_seq #(
        .DP_LAT (DP),
        .ROW_W  (RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: position of the current cycle on the unstalled TU timeline (0 = idle)
    int m_t = 0;
    int m_n = 4;

    // Per-scenario event log
    int rd_n[2], wr_n[2], rd_first[2], rd_last[2], wr_first[2], wr_last[2];
    int done_n, done_cyc, busy_n, busy_first, busy_last;

    int  p;
    bit  st, in_rd, in_wr, e_rpass, e_wpass;
    int  e_ridx, e_widx;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < 2; i++) begin
            rd_n[i] = 0; wr_n[i] = 0;
            rd_first[i] = -1; rd_last[i] = -1;
            wr_first[i] = -1; wr_last[i] = -1;
        end
        done_n = 0; done_cyc = -1;
        busy_n = 0; busy_first = -1; busy_last = -1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input int c, input logic [1:0] sz);
        at_cycle(c);
        bus.start   = 1'b1;
        bus.tu_size = sz;
        at_cycle(c + 1);
        bus.start   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},    int'(bus.busy),    0);
        chk({tag, ".dp_en"},   int'(bus.dp_en),   0);
        chk({tag, ".rd_en"},   int'(bus.rd_en),   0);
        chk({tag, ".rd_idx"},  int'(bus.rd_idx),  0);
        chk({tag, ".pass"},    int'(bus.pass),    0);
        chk({tag, ".wr_en"},   int'(bus.wr_en),   0);
        chk({tag, ".wr_idx"},  int'(bus.wr_idx),  0);
        chk({tag, ".wr_pass"}, int'(bus.wr_pass), 0);
        chk({tag, ".done"},    int'(bus.done),    0);
    endtask

    // Advance the timeline on every unstalled edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            m_t = 0;
        end else if (!bus.stall) begin
            if (m_t == 0) begin
                if (bus.start) begin
                    m_t = 1;
                    m_n = 4 << bus.tu_size;
                end
            end else if (m_t == 2*m_n + 2*DP + 1) begin
                m_t = 0;
            end else begin
                m_t = m_t + 1;
            end
        end
    end

    always @(negedge rst) m_t = 0;

    // Compare against the timeline and log strobes, mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            p  = m_t;
            st = bus.stall;
            in_rd   = (p >= 1 && p <= m_n) || (p >= m_n + DP + 1 && p <= 2*m_n + DP);
            e_rpass = (p > m_n);
            e_ridx  = e_rpass ? p - m_n - DP - 1 : p - 1;
            in_wr   = (p >= DP + 1 && p <= m_n + DP) || (p >= m_n + 2*DP + 1 && p <= 2*m_n + 2*DP);
            e_wpass = (p > m_n + DP);
            e_widx  = e_wpass ? p - m_n - 2*DP - 1 : p - DP - 1;

            chk("busy",  int'(bus.busy),  int'(p > 0));
            chk("dp_en", int'(bus.dp_en), int'(p > 0 && !st));
            chk("rd_en", int'(bus.rd_en), int'(in_rd && !st));
            chk("wr_en", int'(bus.wr_en), int'(in_wr && !st));
            chk("done",  int'(bus.done),  int'(p == 2*m_n + 2*DP + 1 && !st));
            if (in_rd) begin
                chk("rd_idx", int'(bus.rd_idx), e_ridx);
                chk("pass",   int'(bus.pass),   int'(e_rpass));
            end
            if (in_wr) begin
                chk("wr_idx",  int'(bus.wr_idx),  e_widx);
                chk("wr_pass", int'(bus.wr_pass), int'(e_wpass));
            end

            if (bus.rd_en) begin
                rd_n[int'(bus.pass)]++;
                if (rd_first[int'(bus.pass)] < 0) rd_first[int'(bus.pass)] = cyc;
                rd_last[int'(bus.pass)] = cyc;
            end
            if (bus.wr_en) begin
                wr_n[int'(bus.wr_pass)]++;
                if (wr_first[int'(bus.wr_pass)] < 0) wr_first[int'(bus.wr_pass)] = cyc;
                wr_last[int'(bus.wr_pass)] = cyc;
            end
            if (bus.done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (bus.busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
        end
    end

    initial begin
        bus.start   = 1'b0;
        bus.tu_size = 2'd0;
        bus.stall   = 1'b0;
        clear_log();

        #1 rst = 1'b0;
        #1 chk_all_zero("reset");
        at_cycle(3);
        rst = 1'b1;

        // 4x4, start in cycle 10
        clear_log();
        launch(10, 2'd0);
        at_cycle(32);
        chk("t1.rd0_first", rd_first[0], 11);
        chk("t1.rd0_last",  rd_last[0],  14);
        chk("t1.wr0_first", wr_first[0], 15);
        chk("t1.wr0_last",  wr_last[0],  18);
        chk("t1.rd1_first", rd_first[1], 19);
        chk("t1.rd1_last",  rd_last[1],  22);
        chk("t1.wr1_first", wr_first[1], 23);
        chk("t1.wr1_last",  wr_last[1],  26);
        chk("t1.done_cyc",  done_cyc,    27);
        chk("t1.done_n",    done_n,      1);
        chk("t1.busy_first", busy_first, 11);
        chk("t1.busy_n",    busy_n,      17);

        // 32x32, no stall
        clear_log();
        launch(40, 2'd3);
        at_cycle(120);
        chk("t2.rd0_n",    rd_n[0], 32);
        chk("t2.rd1_n",    rd_n[1], 32);
        chk("t2.wr0_n",    wr_n[0], 32);
        chk("t2.wr1_n",    wr_n[1], 32);
        chk("t2.rd0_first", rd_first[0], 41);
        chk("t2.wr0_first", wr_first[0], 45);
        chk("t2.done_cyc", done_cyc, 113);

        // 8x8, 3 stalls in row issue, 2 stalls in column drain
        clear_log();
        launch(130, 2'd1);
        at_cycle(134); bus.stall = 1'b1;
        at_cycle(137); bus.stall = 1'b0;
        at_cycle(155); bus.stall = 1'b1;
        at_cycle(157); bus.stall = 1'b0;
        at_cycle(170);
        chk("t3.rd0_n", rd_n[0], 8);
        chk("t3.rd1_n", rd_n[1], 8);
        chk("t3.wr0_n", wr_n[0], 8);
        chk("t3.wr1_n", wr_n[1], 8);
        // 2*(8+4)+1 unstalled cycles after start, plus 5 stalled ones
        chk("t3.done_cyc", done_cyc, 160);
        chk("t3.done_n",   done_n,   1);

        // start while busy and in the DONE cycle, with other sizes
        clear_log();
        launch(180, 2'd0);
        at_cycle(185); bus.start = 1'b1; bus.tu_size = 2'd3;
        at_cycle(186); bus.start = 1'b0;
        at_cycle(197); bus.start = 1'b1; bus.tu_size = 2'd2;
        at_cycle(198); bus.start = 1'b0;
        at_cycle(210);
        chk("t4.rd0_n",    rd_n[0], 4);
        chk("t4.rd1_n",    rd_n[1], 4);
        chk("t4.done_cyc", done_cyc, 197);
        chk("t4.done_n",   done_n,   1);
        chk("t4.busy_last", busy_last, 197);
        chk("t4.busy_n",   busy_n,   17);

        // asynchronous reset during the column pass of a 16x16
        clear_log();
        launch(220, 2'd2);
        at_cycle(245);
        #2 rst = 1'b0;
        #1 chk_all_zero("t5.async");
        at_cycle(247);
        rst = 1'b1;
        clear_log();
        at_cycle(270);
        chk("t5.wr_after", wr_n[0] + wr_n[1], 0);
        chk("t5.done_after", done_n, 0);
        chk("t5.busy_after", busy_n, 0);
        launch(272, 2'd0);
        at_cycle(295);
        chk("t5.rd0_n",    rd_n[0], 4);
        chk("t5.wr1_n",    wr_n[1], 4);
        chk("t5.done_cyc", done_cyc, 289);

        // stall held in DONE for 4 cycles
        clear_log();
        launch(300, 2'd0);
        at_cycle(317); bus.stall = 1'b1;
        at_cycle(321); bus.stall = 1'b0;
        at_cycle(330);
        chk("t6.done_cyc",  done_cyc,  321);
        chk("t6.done_n",    done_n,    1);
        chk("t6.busy_last", busy_last, 321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
